// File: rtl/stis4_pkg.sv
// Shared constants and types for the TI S-box share pipeline.
package stis4_pkg;

  localparam int STIS4_WIDTH      = 4;
  localparam int STIS4_NUM_SHARES = 3;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  typedef logic [$clog2(STIS4_NUM_SHARES)-1:0] share_idx_t;

endpackage

// File: rtl/stis4_out_reg.sv
// Output register with valid/ready hold, reusable at TI pipeline boundaries.
module stis4_out_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             fire
);

  assign fire = out_valid & out_ready;

  // Consumed data is scrubbed to zero so no recombined value lingers.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= load_data;
      out_valid <= 1'b1;
    end else if (fire) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stis4_share_decoder.sv
// Serial recombination of Boolean shares into one unmasked value.
// Optional share-order checking is enabled with STIS4_SHARE_IDX_CHECK_EN.
module stis4_share_decoder
  import stis4_pkg::*;
#(
  parameter int  NUM_SHARES = STIS4_NUM_SHARES,
  parameter int  WIDTH      = STIS4_WIDTH,
  localparam int CW         = $clog2(NUM_SHARES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] share_data,
  input  logic             share_valid,
  output logic             share_ready,
`ifdef STIS4_SHARE_IDX_CHECK_EN
  input  logic [CW-1:0]    share_idx,
  output logic             err,
`endif
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  state_t           state, state_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [WIDTH-1:0] acc, acc_next;
  logic             busy_next;
  logic             accept;
  logic             last;
  logic             idx_bad;
  logic             load;
  logic             consumed;

  assign share_ready = (state == COLLECT) && !rst;
  assign accept      = share_valid && share_ready;
  assign last        = (cnt == CW'(NUM_SHARES - 1));

`ifdef STIS4_SHARE_IDX_CHECK_EN
  assign idx_bad = (share_idx != cnt);
`else
  assign idx_bad = 1'b0;
`endif

  // Next-state logic; flush overrides any handshake in the same cycle.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    acc_next   = acc;
    busy_next  = busy;
    load       = 1'b0;
    if (flush) begin
      state_next = COLLECT;
      cnt_next   = '0;
      acc_next   = '0;
      busy_next  = 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            if (idx_bad) begin
              cnt_next  = '0;
              acc_next  = '0;
              busy_next = 1'b0;
            end else if (last) begin
              load       = 1'b1;
              cnt_next   = '0;
              acc_next   = '0;
              busy_next  = 1'b1;
              state_next = HOLD;
            end else begin
              cnt_next  = cnt + CW'(1);
              acc_next  = acc ^ share_data;
              busy_next = 1'b1;
            end
          end
        end
        HOLD: begin
          if (consumed) begin
            busy_next  = 1'b0;
            state_next = COLLECT;
          end
        end
        default: state_next = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT;
      cnt   <= '0;
      acc   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      acc   <= acc_next;
      busy  <= busy_next;
    end
  end

`ifdef STIS4_SHARE_IDX_CHECK_EN
  // Sticky until rst or flush so software sees every ordering fault.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      err <= 1'b0;
    end else if (accept && idx_bad) begin
      err <= 1'b1;
    end
  end
`endif

  stis4_out_reg #(
    .WIDTH(WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush),
    .load     (load),
    .load_data(acc ^ share_data),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .fire     (consumed)
  );

endmodule

// File: doc/stis4_share_decoder.md
Name: stis4_share_decoder

Overview:
- Recombines the Boolean shares from the threshold-implemented 4-bit S-box datapath into one unmasked nibble.
- Shares arrive serially, one per cycle, so no two shares ever meet in the same combinational cone before registering. This preserves non-completeness up to the recombination register.
- Sits at the output boundary of the TI S-box pipeline. It is the decoding counterpart of the share-producing coordinate functions.

Parameters:
- NUM_SHARES, 3, number of shares per value (3 = first-order TI); legal range 2..8.
- WIDTH, 4, bits per share and per recombined value.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous abort of the current frame.
- share_data  input  WIDTH  one share of the current value.
- share_valid  input  1  share_data valid.
- share_ready  output  1  decoder accepts share this cycle.
- out_data  output  WIDTH  recombined value (XOR of all shares).
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts out_data.
- busy  output  1  high while at least one share of a frame has been accepted and the frame is not yet consumed.

Behaviour:
- Reset values: share_ready=0 during rst, 1 from the first cycle after rst deasserts. out_valid=0, out_data=0, busy=0. Accumulator and share counter cleared to 0. State=COLLECT.
- Share handshake: a share is accepted when share_valid & share_ready. share_ready is 1 in COLLECT and 0 in HOLD.
- COLLECT, accept with cnt < NUM_SHARES-1: acc <= acc ^ share_data; cnt++; busy=1.
- COLLECT, accept with cnt == NUM_SHARES-1: out_data <= acc ^ share_data; out_valid <= 1; acc <= 0; cnt <= 0; go to HOLD.
- Latency: out_valid rises the cycle after the last share is accepted.
- HOLD: out_data and out_valid are held stable until out_valid & out_ready. On that cycle: out_valid <= 0, out_data <= 0 (scrub), busy <= 0, go to COLLECT.
- No share is accepted in the handshake cycle. Peak throughput is one value per NUM_SHARES+1 cycles.
- out_ready while out_valid=0 is ignored.
- share_valid low in COLLECT: state holds; idle gaps between shares are legal.
- flush has priority over all handshakes in the same cycle. It clears acc, cnt, out_data, out_valid and busy, and returns to COLLECT. A pending output is dropped.
- rst has priority over flush. Reset mid-frame discards partial shares; the next accepted share is share 0.
- cnt width is $clog2(NUM_SHARES) and never wraps past NUM_SHARES-1.
- No combinational path from share_data or share_valid to out_data or out_valid.
- No combinational path from out_ready to share_ready.

Optional Feature:
- Macro: STIS4_SHARE_IDX_CHECK_EN.
- Enabled:
  - Adds input share_idx ($clog2(NUM_SHARES) bits), sampled with each accepted share, and output err (1 bit, reset 0).
  - If share_idx != cnt on acceptance, err <= 1 (sticky until rst or flush). The partial frame is discarded (acc, cnt cleared), and no output is produced for that frame.
- Disabled: share_idx and err ports are absent; arrival order alone defines share number.

Decomposition:
- Shared package stis4_pkg holds:
  - STIS4_WIDTH=4 and STIS4_NUM_SHARES=3 constants;
  - the state enum (COLLECT, HOLD);
  - a share-index typedef sized by $clog2(STIS4_NUM_SHARES).
- No sub-module needed. Optionally, the output register plus valid/ready hold logic is split into stis4_out_reg, reusable at other TI pipeline boundaries.

Test Plan:
- Basic recombine: shares 4'hA, 4'h3, 4'h5 on consecutive cycles, out_ready=1 -> out_valid one cycle after the third share, out_data=4'hC. Next cycle out_data=0, share_ready=1.
- Backpressure: complete frame 4'h1, 4'h2, 4'h4, hold out_ready=0 for 5 cycles with share_valid=1 -> out_data=4'h7 stable and share_ready=0 throughout. First new share is accepted the cycle after the handshake.
- Gaps: shares 4'hF, idle 3 cycles, 4'hF, idle 1 cycle, 4'h8 -> out_data=4'h8, busy=1 from first accept until consumption.
- Reset mid-frame: accept 4'h6, 4'h9, assert rst 1 cycle, then send 4'h1, 4'h2, 4'h4 -> out_data=4'h7, not influenced by 6/9.
- Flush vs. handshake: flush asserted in the same cycle as the third share -> no out_valid. Following frame 4'h3, 4'h3, 4'hE -> out_data=4'hE.
- STIS4_SHARE_IDX_CHECK_EN: idx sequence 0, 2 -> err=1 the cycle after the second accept, no output. Then flush -> err=0. Then idx 0, 1, 2 with 4'hA, 4'h3, 4'h5 -> out_data=4'hC, err stays 0.
